// File: rtl/n64_vdemux.sv
// n64_vdemux: demuxes the VI sync/R/G/B word stream into packed 25-bit pixels; sync-to-strobe 4 cycles (5 with VDEMUX_INPUT_REG_EN).
// No backpressure: one strobe per 4-cycle pixel while locked, vdata_o held stable between strobes.
module n64_vdemux #(
    parameter int color_width  = 7,
    parameter int LOCK_PERIODS = 4
) (
    input  logic                     VCLK,
    input  logic                     nRST,
    input  logic                     nDSYNC_i,
    input  logic [color_width-1:0]   D_i,
    output logic                     vdata_valid_o,
    output logic [3*color_width+3:0] vdata_o,
    output logic                     locked_o,
    output logic [7:0]               err_cnt_o
);

    localparam int         W         = 3*color_width + 4;
    localparam logic [3:0] LOCK_LAST = 4'(LOCK_PERIODS - 1);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    logic                   nds;
    logic [color_width-1:0] dat;

`ifdef VDEMUX_INPUT_REG_EN
    logic                   nds_q;
    logic [color_width-1:0] dat_q;

    always_ff @(posedge VCLK) begin
        if (!nRST) begin
            nds_q <= 1'b1;
            dat_q <= '0;
        end else begin
            nds_q <= nDSYNC_i;
            dat_q <= D_i;
        end
    end

    assign nds = nds_q;
    assign dat = dat_q;
`else
    assign nds = nDSYNC_i;
    assign dat = D_i;
`endif

    state_t         state;
    logic [1:0]     phase;
    logic [3:0]     pcnt;
    logic           armed;
    logic [W-1:0]   shadow;
    logic           pend;
    logic           err_early;
    logic           err_missing;

    // phase holds the position of the word about to be sampled
    always_comb begin
        err_early   = 1'b0;
        err_missing = 1'b0;
        if (state == LOCKED) begin
            err_early   = !nds && (phase != 2'd0);
            err_missing =  nds && (phase == 2'd0);
        end
    end

    always_ff @(posedge VCLK) begin
        if (!nRST) begin
            state         <= SEARCH;
            phase         <= 2'd0;
            pcnt          <= 4'd0;
            armed         <= 1'b0;
            shadow        <= '0;
            pend          <= 1'b0;
            vdata_valid_o <= 1'b0;
            vdata_o       <= '0;
            locked_o      <= 1'b0;
            err_cnt_o     <= 8'd0;
        end else begin
            vdata_valid_o <= pend;
            if (pend) begin
                vdata_o <= shadow;
            end
            pend  <= (state == LOCKED) && nds && (phase == 2'd3);
            phase <= nds ? phase + 2'd1 : 2'd1;

            if (!nds) begin
                shadow[W-1 -: 4] <= dat[3:0];
            end else begin
                case (phase)
                    2'd1:    shadow[3*color_width-1 -: color_width] <= dat;
                    2'd2:    shadow[2*color_width-1 -: color_width] <= dat;
                    2'd3:    shadow[color_width-1:0]                <= dat;
                    default: ;
                endcase
            end

            if (err_early || err_missing) begin
                state    <= SEARCH;
                locked_o <= 1'b0;
                pcnt     <= 4'd0;
                // an early low starts a new candidate period, a missing one does not
                armed    <= err_early;
                if (err_cnt_o != 8'hFF) begin
                    err_cnt_o <= err_cnt_o + 8'd1;
                end
            end else if (state == SEARCH) begin
                if (!nds) begin
                    armed <= 1'b1;
                    if (armed && (phase == 2'd0)) begin
                        pcnt <= pcnt + 4'd1;
                        if (pcnt == LOCK_LAST) begin
                            state    <= LOCKED;
                            locked_o <= 1'b1;
                        end
                    end else begin
                        pcnt <= 4'd0;
                    end
                end else if (phase == 2'd0) begin
                    armed <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_n64_vdemux.sv
// Randomised bench for n64_vdemux against a time-stamp based reference model of the VI word stream.
module tb_n64_vdemux;

`ifdef VDEMUX_INPUT_REG_EN
    localparam int IREG = 1;
`else
    localparam int IREG = 0;
`endif
    localparam int LOCK_PERIODS = 4;

    logic        VCLK = 1'b0;
    logic        nRST = 1'b1;
    logic        nDSYNC_i = 1'b1;
    logic [6:0]  D_i = 7'd0;
    logic        vdata_valid_o;
    logic [24:0] vdata_o;
    logic        locked_o;
    logic [7:0]  err_cnt_o;

    n64_vdemux dut (
        .VCLK          (VCLK),
        .nRST          (nRST),
        .nDSYNC_i      (nDSYNC_i),
        .D_i           (D_i),
        .vdata_valid_o (vdata_valid_o),
        .vdata_o       (vdata_o),
        .locked_o      (locked_o),
        .err_cnt_o     (err_cnt_o)
    );

    always #5 VCLK = ~VCLK;

    int vectors = 0;
    int miscompares = 0;

    wire  [34:0] dut_t = {vdata_valid_o, vdata_o, locked_o, err_cnt_o};
    logic [34:0] mdl_t;

    // reference model: tracks sample times of nDSYNC lows rather than a phase counter
    int          m_n, m_pcnt, m_last_low, m_psync, m_err;
    bit          m_locked, m_valid, m_pend;
    logic [24:0] m_vdata, m_word;
    logic [3:0]  m_sync;
    logic [6:0]  m_r, m_g;
    logic        m_ds_q;
    logic [6:0]  m_d_q;

    logic       q_s[$];
    logic [6:0] q_d[$];
    logic       q_r[$];

    task automatic model_update(input logic s, input logic [6:0] d, input logic r);
        logic       es;
        logic [6:0] ed;
        int         off;
        bit         err_now;
        if (!r) begin
            m_n = 0; m_pcnt = 0; m_last_low = -100; m_psync = 0; m_err = 0;
            m_locked = 0; m_valid = 0; m_pend = 0; m_vdata = '0; m_word = '0;
            m_ds_q = 1'b1; m_d_q = '0;
        end else begin
            if (IREG != 0) begin
                es = m_ds_q; ed = m_d_q; m_ds_q = s; m_d_q = d;
            end else begin
                es = s; ed = d;
            end
            m_n++;
            m_valid = m_pend;
            if (m_pend) m_vdata = m_word;
            m_pend  = 0;
            err_now = 0;
            if (m_locked) begin
                off = m_n - m_psync;
                if (!es && off == 4) begin
                    m_psync = m_n; m_sync = ed[3:0];
                end else if (!es) begin
                    err_now = 1; m_last_low = m_n; m_sync = ed[3:0];
                end else if (off == 4) begin
                    err_now = 1; m_last_low = -100;
                end else begin
                    if (off == 1) m_r = ed;
                    if (off == 2) m_g = ed;
                    if (off == 3) begin
                        m_word = {m_sync, m_r, m_g, ed};
                        m_pend = 1;
                    end
                end
                if (err_now) begin
                    m_locked = 0; m_pcnt = 0;
                    if (m_err < 255) m_err++;
                end
            end else if (!es) begin
                m_sync = ed[3:0];
                if (m_n - m_last_low == 4) begin
                    m_pcnt++;
                    if (m_pcnt == LOCK_PERIODS) begin
                        m_locked = 1; m_psync = m_n;
                    end
                end else begin
                    m_pcnt = 0;
                end
                m_last_low = m_n;
            end
        end
        mdl_t = {m_valid, m_vdata, m_locked, m_err[7:0]};
    endtask

    task automatic step(input logic s, input logic [6:0] d, input logic r);
        @(negedge VCLK);
        nRST = r; nDSYNC_i = s; D_i = d;
        @(posedge VCLK);
        model_update(s, d, r);
        #1;
    endtask

    task automatic q_clear();
        q_s.delete(); q_d.delete(); q_r.delete();
    endtask

    task automatic push(input logic s, input logic [6:0] d);
        q_s.push_back(s); q_d.push_back(d); q_r.push_back(1'b1);
    endtask

    task automatic push_pix(input logic [3:0] sy, input logic [6:0] r, input logic [6:0] g, input logic [6:0] b);
        logic [2:0] junk;
        junk = 3'($urandom);
        push(1'b0, {junk, sy});
        push(1'b1, r);
        push(1'b1, g);
        push(1'b1, b);
    endtask

    task automatic push_rand_pix();
        push_pix(4'($urandom), 7'($urandom), 7'($urandom), 7'($urandom));
    endtask

    task automatic test_reset();
        q_clear();
        push(1'b1, 7'h55); q_r[0] = 1'b0;
        push(1'b1, 7'h2A); q_r[1] = 1'b0;
        for (int k = 0; k < 4; k++) push(1'b1, 7'($urandom));
        for (int i = 0; i < q_s.size(); i++) begin
            step(q_s[i], q_d[i], q_r[i]);
            vectors++;
            if (dut_t !== mdl_t) begin
                miscompares++;
                $display("FAIL reset_model cyc %0d: got %h want %h", i, dut_t, mdl_t);
            end
            vectors++;
            if (dut_t !== 35'd0) begin
                miscompares++;
                $display("FAIL reset_zero cyc %0d: got %h want 0", i, dut_t);
            end
        end
    endtask

    task automatic test_lock();
        int          rise_at;
        logic        exp_v;
        logic [24:0] first_w;
        first_w = {4'hF, 7'h11, 7'h22, 7'h33};
        rise_at = 16 + IREG;
        q_clear();
        for (int k = 0; k < 8; k++) push_pix(4'hF, 7'h11, 7'h22, 7'h33);
        for (int i = 0; i < q_s.size(); i++) begin
            step(q_s[i], q_d[i], q_r[i]);
            vectors++;
            if (dut_t !== mdl_t) begin
                miscompares++;
                $display("FAIL lock_model cyc %0d: got %h want %h", i, dut_t, mdl_t);
            end
            if (i == rise_at - 1 || i == rise_at) begin
                vectors++;
                if (locked_o !== (i == rise_at)) begin
                    miscompares++;
                    $display("FAIL lock_rise cyc %0d: got %b want %b", i, locked_o, (i == rise_at));
                end
            end
            if (i >= rise_at) begin
                exp_v = (i > rise_at) && ((i - rise_at) % 4 == 0);
                vectors++;
                if (vdata_valid_o !== exp_v) begin
                    miscompares++;
                    $display("FAIL lock_cadence cyc %0d: got %b want %b", i, vdata_valid_o, exp_v);
                end
            end
            if (i == rise_at + 4) begin
                vectors++;
                if (vdata_o !== first_w) begin
                    miscompares++;
                    $display("FAIL lock_first_pixel: got %h want %h", vdata_o, first_w);
                end
            end
        end
    endtask

    task automatic test_hold();
        logic [24:0] prev;
        int          strobes;
        q_clear();
        push_pix(4'($urandom), 7'h01, 7'h02, 7'h03);
        push_pix(4'($urandom), 7'h7F, 7'h40, 7'h00);
        for (int k = 0; k < 6; k++) push_rand_pix();
        prev    = m_vdata;
        strobes = 0;
        for (int i = 0; i < q_s.size(); i++) begin
            step(q_s[i], q_d[i], q_r[i]);
            vectors++;
            if (dut_t !== mdl_t) begin
                miscompares++;
                $display("FAIL hold_model cyc %0d: got %h want %h", i, dut_t, mdl_t);
            end
            if (vdata_valid_o === 1'b1) strobes++;
            else begin
                vectors++;
                if (vdata_o !== prev) begin
                    miscompares++;
                    $display("FAIL hold_stable cyc %0d: got %h want %h", i, vdata_o, prev);
                end
            end
            prev = vdata_o;
            if (i == 4 + IREG) begin
                vectors++;
                if ({vdata_valid_o, vdata_o[20:0]} !== {1'b1, 7'h01, 7'h02, 7'h03}) begin
                    miscompares++;
                    $display("FAIL hold_pix1: got %b/%h want 1/%h", vdata_valid_o, vdata_o[20:0], {7'h01, 7'h02, 7'h03});
                end
            end
            if (i == 8 + IREG) begin
                vectors++;
                if ({vdata_valid_o, vdata_o[20:0]} !== {1'b1, 7'h7F, 7'h40, 7'h00}) begin
                    miscompares++;
                    $display("FAIL hold_pix2: got %b/%h want 1/%h", vdata_valid_o, vdata_o[20:0], {7'h7F, 7'h40, 7'h00});
                end
            end
        end
        vectors++;
        if (strobes != 8) begin
            miscompares++;
            $display("FAIL hold_strobe_count: got %0d want 8", strobes);
        end
    endtask

    task automatic test_early();
        int e;
        e = 2 + IREG;
        q_clear();
        push(1'b0, 7'h0A);
        push(1'b1, 7'($urandom));
        for (int k = 0; k < 6; k++) push_rand_pix();
        vectors++;
        if (err_cnt_o !== 8'd0) begin
            miscompares++;
            $display("FAIL early_err_before: got %0d want 0", err_cnt_o);
        end
        for (int i = 0; i < q_s.size(); i++) begin
            step(q_s[i], q_d[i], q_r[i]);
            vectors++;
            if (dut_t !== mdl_t) begin
                miscompares++;
                $display("FAIL early_model cyc %0d: got %h want %h", i, dut_t, mdl_t);
            end
            if (i == e - 1 || i == e || i == e + 15 || i == e + 16) begin
                vectors++;
                if (locked_o !== (i == e - 1 || i == e + 16)) begin
                    miscompares++;
                    $display("FAIL early_lock cyc %0d: got %b want %b", i, locked_o, (i == e - 1 || i == e + 16));
                end
            end
            if (i >= 1 + IREG && i <= e + 20) begin
                vectors++;
                if (vdata_valid_o !== (i == e + 20)) begin
                    miscompares++;
                    $display("FAIL early_strobe cyc %0d: got %b want %b", i, vdata_valid_o, (i == e + 20));
                end
            end
        end
        vectors++;
        if (err_cnt_o !== 8'd1) begin
            miscompares++;
            $display("FAIL early_err_after: got %0d want 1", err_cnt_o);
        end
    endtask

    task automatic test_missing();
        int e0;
        e0 = m_err;
        q_clear();
        push_rand_pix();
        for (int k = 0; k < 8; k++) push(1'b1, 7'($urandom));
        for (int k = 0; k < 7; k++) push_rand_pix();
        for (int i = 0; i < q_s.size(); i++) begin
            step(q_s[i], q_d[i], q_r[i]);
            vectors++;
            if (dut_t !== mdl_t) begin
                miscompares++;
                $display("FAIL missing_model cyc %0d: got %h want %h", i, dut_t, mdl_t);
            end
            if (i == 3 + IREG || i == 4 + IREG || i == 27 + IREG || i == 28 + IREG) begin
                vectors++;
                if (locked_o !== (i == 3 + IREG || i == 28 + IREG)) begin
                    miscompares++;
                    $display("FAIL missing_lock cyc %0d: got %b want %b", i, locked_o, (i == 3 + IREG || i == 28 + IREG));
                end
            end
            if (i >= 5 + IREG && i <= 11 + IREG) begin
                vectors++;
                if (vdata_valid_o !== 1'b0) begin
                    miscompares++;
                    $display("FAIL missing_gap_strobe cyc %0d: got 1 want 0", i);
                end
            end
        end
        vectors++;
        if (err_cnt_o !== 8'(e0 + 1)) begin
            miscompares++;
            $display("FAIL missing_err: got %0d want %0d", err_cnt_o, e0 + 1);
        end
    endtask

    task automatic test_random();
        int kind, len;
        q_clear();
        for (int k = 0; k < 150; k++) begin
            kind = $urandom_range(0, 19);
            if (kind == 0) begin
                len = $urandom_range(1, 3);
                push(1'b0, 7'($urandom));
                for (int j = 1; j < len; j++) push(1'b1, 7'($urandom));
            end else if (kind == 1) begin
                len = $urandom_range(1, 6);
                for (int j = 0; j < len; j++) push(1'b1, 7'($urandom));
            end else begin
                push_rand_pix();
            end
        end
        for (int i = 0; i < q_s.size(); i++) begin
            step(q_s[i], q_d[i], q_r[i]);
            vectors++;
            if (dut_t !== mdl_t) begin
                miscompares++;
                $display("FAIL random_model cyc %0d: got %h want %h", i, dut_t, mdl_t);
            end
        end
    endtask

    task automatic test_saturate_reset();
        int   falls;
        logic prev_l;
        int   rise_at;
        q_clear();
        for (int k = 0; k < 305; k++) begin
            for (int j = 0; j < 4; j++) push_rand_pix();
            push(1'b0, 7'($urandom));
            push(1'b1, 7'($urandom));
        end
        falls  = 0;
        prev_l = locked_o;
        for (int i = 0; i < q_s.size(); i++) begin
            step(q_s[i], q_d[i], q_r[i]);
            vectors++;
            if (dut_t !== mdl_t) begin
                miscompares++;
                $display("FAIL sat_model cyc %0d: got %h want %h", i, dut_t, mdl_t);
            end
            if (prev_l === 1'b1 && locked_o === 1'b0) falls++;
            prev_l = locked_o;
        end
        vectors++;
        if (err_cnt_o !== 8'd255 || falls < 300) begin
            miscompares++;
            $display("FAIL sat_hold: got err %0d after %0d losses want err 255 after >=300", err_cnt_o, falls);
        end

        rise_at = 20 + IREG;
        q_clear();
        push(1'b0, 7'h0F);
        push(1'b1, 7'h11);
        push(1'b1, 7'h22); q_r[2] = 1'b0;
        push(1'b1, 7'h33);
        for (int k = 0; k < 6; k++) push_rand_pix();
        for (int i = 0; i < q_s.size(); i++) begin
            step(q_s[i], q_d[i], q_r[i]);
            vectors++;
            if (dut_t !== mdl_t) begin
                miscompares++;
                $display("FAIL rst_model cyc %0d: got %h want %h", i, dut_t, mdl_t);
            end
            if (i == 2) begin
                vectors++;
                if (dut_t !== 35'd0) begin
                    miscompares++;
                    $display("FAIL rst_zero: got %h want 0", dut_t);
                end
            end
            if (i >= 2 && i <= rise_at) begin
                vectors++;
                if (locked_o !== (i == rise_at)) begin
                    miscompares++;
                    $display("FAIL rst_relock cyc %0d: got %b want %b", i, locked_o, (i == rise_at));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_hold();
        test_early();
        test_missing();
        test_random();
        test_saturate_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
